cp0_regfile: RTL and testbench

CP0_REGFILE -- requirements
Module: cp0_regfile

---
 rtl/cp0_regfile.sv | 206 ++++++++++++++++++++
 tb/tb_cp0_regfile.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// MIPS-style coprocessor 0 register file: STATUS, CAUSE, EPC, BADVADDR, COUNT, COMPARE,
// with the timer interrupt, exception/ERET bookkeeping and the registered interrupt request.
module cp0_regfile #(
   parameter int COUNT_DIV = 2,
   parameter int EXT_INT_W = 6,
   parameter int TIMER_IP  = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           c0_addr,
   input  logic                 mtc0_we,
   input  logic [31:0]          c0_wdata,
   input  logic [4:0]           raddr,
   output logic [31:0]          rdata,
   input  logic                 wb_except,
   input  logic [4:0]           wb_excode,
   input  logic                 wb_bd,
   input  logic [31:0]          wb_pc,
   input  logic [31:0]          wb_badvaddr,
   input  logic                 eret_flush,
   input  logic [EXT_INT_W-1:0] ext_int_in,
   output logic                 int_pending,
   output logic [31:0]          epc_out,
   output logic [31:0]          exc_vector
);

   localparam logic [4:0] ADDR_BADVADDR = 5'd8;
   localparam logic [4:0] ADDR_COUNT    = 5'd9;
   localparam logic [4:0] ADDR_COMPARE  = 5'd11;
   localparam logic [4:0] ADDR_STATUS   = 5'd12;
   localparam logic [4:0] ADDR_CAUSE    = 5'd13;
   localparam logic [4:0] ADDR_EPC      = 5'd14;

   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;

   localparam logic STATUS_BEV = 1'b1;

   localparam int                 PRESC_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(COUNT_DIV - 1);

   // STATUS fields
   logic [7:0]         r_im;
   logic               r_exl;
   logic               r_ie;
   // CAUSE fields
   logic               r_bd;
   logic               r_ti;
   logic [5:0]         r_ip_hw;
   logic [1:0]         r_ip_sw;
   logic [4:0]         r_exccode;
   // Address and timer registers
   logic [31:0]        r_epc;
   logic [31:0]        r_badvaddr;
   logic [31:0]        r_count;
   logic [31:0]        r_compare;
   logic [PRESC_W-1:0] r_presc;
   logic               r_count_load;
   logic               r_int_pending;

   logic               w_mtc0_ok;
   logic               w_wr_status;
   logic               w_wr_cause;
   logic               w_wr_epc;
   logic               w_wr_count;
   logic               w_wr_compare;
   logic               w_presc_tick;
   logic [5:0]         w_ext_pad;
   logic [5:0]         w_timer_mask;
   logic [7:0]         w_ip;
   logic [31:0]        w_status;
   logic [31:0]        w_cause;

   // A committing exception squashes the mtc0 that sits beside it in WB.
   assign w_mtc0_ok    = mtc0_we & ~wb_except;
   assign w_wr_status  = w_mtc0_ok & (c0_addr == ADDR_STATUS);
   assign w_wr_cause   = w_mtc0_ok & (c0_addr == ADDR_CAUSE);
   assign w_wr_epc     = w_mtc0_ok & (c0_addr == ADDR_EPC);
   assign w_wr_count   = w_mtc0_ok & (c0_addr == ADDR_COUNT);
   assign w_wr_compare = w_mtc0_ok & (c0_addr == ADDR_COMPARE);

   assign w_presc_tick = (r_presc == PRESC_LAST);

   assign w_ext_pad    = 6'(ext_int_in);
   assign w_timer_mask = 6'(1) << (TIMER_IP - 2);
   assign w_ip         = {r_ip_hw | (r_ti ? w_timer_mask : 6'b0), r_ip_sw};

   assign w_status = {9'b0, STATUS_BEV, 6'b0, r_im, 6'b0, r_exl, r_ie};
   assign w_cause  = {r_bd, r_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};

   // NOTE: state is updated only with non-blocking assignments so every block samples
   // the pre-edge values of the others, regardless of evaluation order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_im  <= '0;
         r_ie  <= 1'b0;
         r_exl <= 1'b0;
      end else begin
         if (w_wr_status) begin
            r_im <= c0_wdata[15:8];
            r_ie <= c0_wdata[0];
         end
         if (wb_except) begin
            r_exl <= 1'b1;
         end else if (eret_flush) begin
            r_exl <= 1'b0;
         end else if (w_wr_status) begin
            r_exl <= c0_wdata[1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bd       <= 1'b0;
         r_exccode  <= '0;
         r_epc      <= '0;
         r_badvaddr <= '0;
      end else if (wb_except) begin
         r_exccode <= wb_excode;
         // A nested exception keeps the original return point.
         if (!r_exl) begin
            r_bd  <= wb_bd;
            r_epc <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
         end
         if (wb_excode == EXC_ADEL || wb_excode == EXC_ADES) begin
            r_badvaddr <= wb_badvaddr;
         end
      end else if (w_wr_epc) begin
         r_epc <= c0_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ip_hw <= '0;
         r_ip_sw <= '0;
      end else begin
         r_ip_hw <= w_ext_pad;
         if (w_wr_cause) begin
            r_ip_sw <= c0_wdata[9:8];
         end
      end
   end

   // r_count_load marks the cycle after COUNT took a new value, so the compare
   // fires once per arrival rather than for as long as COUNT dwells on COMPARE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count      <= '0;
         r_presc      <= '0;
         r_count_load <= 1'b0;
      end else if (w_wr_count) begin
         r_count      <= c0_wdata;
         r_presc      <= '0;
         r_count_load <= 1'b1;
      end else if (w_presc_tick) begin
         r_count      <= r_count + 32'd1;
         r_presc      <= '0;
         r_count_load <= 1'b1;
      end else begin
         r_presc      <= r_presc + PRESC_W'(1);
         r_count_load <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_compare <= '0;
         r_ti      <= 1'b0;
      end else if (w_wr_compare) begin
         r_compare <= c0_wdata;
         r_ti      <= 1'b0;
      end else if (r_count_load && (r_count == r_compare)) begin
         r_ti <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || wb_except) begin
         r_int_pending <= 1'b0;
      end else begin
         r_int_pending <= r_ie & ~r_exl & (|(r_im & w_ip));
      end
   end

   // NOTE: rdata gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      rdata = '0;
      case (raddr)
         ADDR_BADVADDR: rdata = r_badvaddr;
         ADDR_COUNT:    rdata = r_count;
         ADDR_COMPARE:  rdata = r_compare;
         ADDR_STATUS:   rdata = w_status;
         ADDR_CAUSE:    rdata = w_cause;
         ADDR_EPC:      rdata = r_epc;
         default:       rdata = '0;
      endcase
   end

   assign int_pending = r_int_pending;
   assign epc_out     = r_epc;
   assign exc_vector  = STATUS_BEV ? 32'hBFC0_0380 : 32'h8000_0180;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile (COUNT_DIV=2, EXT_INT_W=2, TIMER_IP=7).
module tb_cp0_regfile;

   localparam logic [4:0] A_BADV = 5'd8;
   localparam logic [4:0] A_CNT  = 5'd9;
   localparam logic [4:0] A_CMP  = 5'd11;
   localparam logic [4:0] A_STS  = 5'd12;
   localparam logic [4:0] A_CAU  = 5'd13;
   localparam logic [4:0] A_EPC  = 5'd14;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  c0_addr;
   logic        mtc0_we;
   logic [31:0] c0_wdata;
   logic [4:0]  raddr;
   logic [31:0] rdata;
   logic        wb_except;
   logic [4:0]  wb_excode;
   logic        wb_bd;
   logic [31:0] wb_pc;
   logic [31:0] wb_badvaddr;
   logic        eret_flush;
   logic [1:0]  ext_int_in;
   logic        int_pending;
   logic [31:0] epc_out;
   logic [31:0] exc_vector;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] v;

   cp0_regfile #(.COUNT_DIV(2), .EXT_INT_W(2), .TIMER_IP(7)) dut (
      .clk(clk), .reset(reset), .c0_addr(c0_addr), .mtc0_we(mtc0_we), .c0_wdata(c0_wdata),
      .raddr(raddr), .rdata(rdata), .wb_except(wb_except), .wb_excode(wb_excode),
      .wb_bd(wb_bd), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush),
      .ext_int_in(ext_int_in), .int_pending(int_pending), .epc_out(epc_out),
      .exc_vector(exc_vector)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      raddr = a;
      #1;
      d = rdata;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      c0_addr  = a;
      c0_wdata = d;
      mtc0_we  = 1'b1;
   endtask

   task automatic exc(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                      input logic [31:0] badv);
      wb_except   = 1'b1;
      wb_excode   = code;
      wb_bd       = bd;
      wb_pc       = pc;
      wb_badvaddr = badv;
   endtask

   task automatic idle();
      mtc0_we    = 1'b0;
      wb_except  = 1'b0;
      eret_flush = 1'b0;
   endtask

   initial begin
      reset = 1'b1; c0_addr = '0; mtc0_we = 1'b0; c0_wdata = '0; raddr = '0;
      wb_except = 1'b0; wb_excode = '0; wb_bd = 1'b0; wb_pc = '0; wb_badvaddr = '0;
      eret_flush = 1'b0; ext_int_in = '0;
      tick(); tick();
      rd(A_STS, v); check("rst_status", v, 32'h0040_0000);
      rd(A_CAU, v); check("rst_cause", v, 32'h0);
      rd(A_CNT, v); check("rst_count", v, 32'h0);
      rd(A_EPC, v); check("rst_epc", v, 32'h0);
      check("rst_int", 32'(int_pending), 32'h0);
      check("rst_vector", exc_vector, 32'hBFC0_0380);

      // Timer: COMPARE=5, COUNT reaches 5 on edge 10, TI on edge 11
      reset = 1'b0;
      wr(A_CMP, 32'd5); tick(); idle();
      repeat (8) tick();
      rd(A_CNT, v); check("count_e9", v, 32'd4);
      tick();
      rd(A_CNT, v); check("count_e10", v, 32'd5);
      rd(A_CAU, v); check("ti_not_yet", v, 32'h0);
      tick();
      rd(A_CAU, v); check("ti_set", v, 32'h4000_8000);
      wr(A_STS, 32'h0000_8001); tick(); idle();
      check("int_lag", 32'(int_pending), 32'h0);
      rd(A_STS, v); check("status_wr", v, 32'h0040_8001);
      tick();
      check("int_timer", 32'(int_pending), 32'h1);
      wr(A_CMP, 32'h1000);
      rd(A_CMP, v); check("no_bypass", v, 32'd5);
      tick(); idle();
      rd(A_CAU, v); check("ti_clear", v, 32'h0);
      rd(A_CMP, v); check("compare_wr", v, 32'h1000);
      tick();
      check("int_drop", 32'(int_pending), 32'h0);

      // Exception in a delay slot, then a nested exception
      exc(5'h04, 1'b1, 32'h8000_1004, 32'h0000_1233); tick(); idle();
      rd(A_EPC, v); check("epc_bd", v, 32'h8000_1000);
      check("epc_out", epc_out, 32'h8000_1000);
      rd(A_BADV, v); check("badv_load", v, 32'h0000_1233);
      rd(A_CAU, v); check("cause_exc", v, 32'h8000_0010);
      rd(A_STS, v); check("exl_set", v, 32'h0040_8003);
      check("int_kill", 32'(int_pending), 32'h0);
      exc(5'h0C, 1'b0, 32'h0000_9000, 32'h0000_DEAD); tick(); idle();
      rd(A_EPC, v); check("epc_nested", v, 32'h8000_1000);
      rd(A_CAU, v); check("cause_nested", v, 32'h8000_0030);
      rd(A_BADV, v); check("badv_hold", v, 32'h0000_1233);

      // mtc0 STATUS squashed by a coincident exception; ERET priorities
      exc(5'h00, 1'b0, 32'h1, 32'h0); wr(A_STS, 32'h0); tick(); idle();
      rd(A_STS, v); check("mtc0_squash", v, 32'h0040_8003);
      eret_flush = 1'b1; tick(); idle();
      rd(A_STS, v); check("eret_clr", v, 32'h0040_8001);
      eret_flush = 1'b1; exc(5'h0C, 1'b0, 32'h8000_3000, 32'h0); tick(); idle();
      rd(A_STS, v); check("exl_wins", v, 32'h0040_8003);
      rd(A_EPC, v); check("epc_nobd", v, 32'h8000_3000);
      rd(A_CAU, v); check("cause_nobd", v, 32'h0000_0030);
      eret_flush = 1'b1; tick(); idle();
      exc(5'h05, 1'b0, 32'h8000_2000, 32'h0000_4444); tick(); idle();
      rd(A_EPC, v); check("epc_ades", v, 32'h8000_2000);
      rd(A_BADV, v); check("badv_ades", v, 32'h0000_4444);
      rd(A_CAU, v); check("cause_ades", v, 32'h0000_0014);
      eret_flush = 1'b1; tick(); idle();

      // Hardware interrupt lines and software IP bits
      ext_int_in = 2'b10; tick();
      rd(A_CAU, v); check("ip_hw", v, 32'h0000_0814);
      wr(A_CAU, 32'h0000_0300); tick(); idle();
      rd(A_CAU, v); check("ip_sw", v, 32'h0000_0B14);
      rd(5'd15, v); check("unmapped15", v, 32'h0);
      rd(5'd0, v); check("unmapped0", v, 32'h0);
      check("int_masked", 32'(int_pending), 32'h0);
      wr(A_STS, 32'h0000_0801); tick(); idle(); tick();
      check("int_hw", 32'(int_pending), 32'h1);
      exc(5'h00, 1'b0, 32'h8000_4000, 32'h0); tick(); idle();
      check("int_forced0", 32'(int_pending), 32'h0);
      eret_flush = 1'b1; tick(); idle();

      // COUNT wrap to COMPARE=0
      wr(A_CMP, 32'h0); tick();
      wr(A_CNT, 32'hFFFF_FFFF); tick(); idle();
      tick();
      rd(A_CNT, v); check("count_hold", v, 32'hFFFF_FFFF);
      tick();
      rd(A_CNT, v); check("count_wrap", v, 32'h0);
      rd(A_CAU, v); check("ti_wrap_early", 32'(v[30]), 32'h0);
      tick();
      rd(A_CAU, v); check("ti_wrap", 32'(v[30]), 32'h1);

      // Same wrap, but a COMPARE write lands on the TI-set cycle
      wr(A_CMP, 32'h0); tick();
      wr(A_CNT, 32'hFFFF_FFFF); tick(); idle();
      tick(); tick();
      wr(A_CMP, 32'h0); tick(); idle();
      rd(A_CAU, v); check("ti_clr_wins", 32'(v[30]), 32'h0);
      tick();
      rd(A_CAU, v); check("ti_no_reset", 32'(v[30]), 32'h0);

      // Reset overrides concurrent exception, ERET and mtc0
      reset = 1'b1; exc(5'h04, 1'b1, 32'h8000_5004, 32'h5555);
      wr(A_STS, 32'h0000_FF03); eret_flush = 1'b1;
      tick(); idle(); reset = 1'b0;
      rd(A_STS, v); check("mid_rst_status", v, 32'h0040_0000);
      rd(A_CAU, v); check("mid_rst_cause", v, 32'h0);
      rd(A_EPC, v); check("mid_rst_epc", v, 32'h0);
      rd(A_BADV, v); check("mid_rst_badv", v, 32'h0);
      rd(A_CNT, v); check("mid_rst_count", v, 32'h0);
      check("mid_rst_int", 32'(int_pending), 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
